vline_motion_ctrl: RTL and testbench

Motion sequencer that drives the `UP`/`DW`/`LD` controls of the vertical-line Y-coordinate counter (`vline_move_5`). It sits directly upstream of that counter and consumes its limit flags (`YcoordinateUTC` at Y = 487, `DTC` at Y = 18). Once per configurable number of video frames it issues a single-cycle step pulse, reverses direction at either limit after an optional dwell, and sequences initial load, pause and restart.

---
 rtl/vline_pkg.sv | 28 ++
 rtl/frame_divider.sv | 39 +++
 rtl/vline_motion_ctrl.sv | 154 +++++++++++++++
 tb/tb_vline_motion_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vline_pkg.sv
// Shared types and constants for the vertical-line motion sequencer and the
// Y-coordinate counter it drives.
package vline_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DWELL = 3'd3,
        ST_HOLD  = 3'd4
    } vline_state_t;

    localparam logic [9:0] Y_MAX = 10'd487;
    localparam logic [9:0] Y_MIN = 10'd18;

    localparam int CNT_W = 8;

    // A zero-length dwell still needs a legal modulus for its divider.
    function automatic int unsigned divider_modulus(input int unsigned n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

    // Counter-side compare: {at_max, at_min} for a given Y coordinate.
    function automatic logic [1:0] limit_flags(input logic [9:0] y);
        return {(y == Y_MAX), (y == Y_MIN)};
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Modulo-N frame-tick counter with synchronous clear and a wrap strobe that
// fires on the tick that returns the count to zero.
module frame_divider
    import vline_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic tick,
    output logic wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 32'd1);

    logic [CNT_W-1:0] cnt_r;

    assign wrap = en & tick & ~clr & (cnt_r == LAST);

    // Tick counter; clear has priority over counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en && tick) begin
            if (cnt_r == LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/vline_motion_ctrl.sv
// Motion sequencer for the vertical-line Y counter: paces UP/DW steps off
// frame ticks, reverses at the limits after a dwell, and sequences load/pause.
module vline_motion_ctrl
    import vline_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned DWELL_FRAMES    = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       go,
    input  logic       restart,
    input  logic       at_max,
    input  logic       at_min,
    output logic       UP,
    output logic       DW,
    output logic       LD,
    output logic       dir,
    output logic [2:0] state
);

    localparam bit          HAS_DWELL = (DWELL_FRAMES > 32'd0);
    localparam int unsigned DWELL_MOD = divider_modulus(DWELL_FRAMES);

    vline_state_t state_r;
    vline_state_t state_nxt_s;

    logic dir_r, dir_nxt_s;
    logic up_r, dw_r, ld_r;
    logic up_s, dw_s, ld_s;

    logic active_s;
    logic step_en_s, step_clr_s, step_wrap_s;
    logic dwell_en_s, dwell_clr_s, dwell_wrap_s;
    logic at_limit_s, reverse_s;

    // Restart and pause pre-empt both dividers, so a coincident tick is lost.
    assign active_s    = go & ~restart;
    assign step_en_s   = active_s & (state_r == ST_RUN);
    assign step_clr_s  = (state_r == ST_LOAD);
    assign dwell_en_s  = active_s & (state_r == ST_DWELL);
    assign dwell_clr_s = (state_r != ST_DWELL);

    // Only the flag facing the current direction matters, so an illegal
    // both-flags-high input is resolved by dir.
    assign at_limit_s = dir_r ? at_max : at_min;
    assign reverse_s  = step_wrap_s & at_limit_s;

    frame_divider #(.N(FRAMES_PER_STEP)) u_step_div (
        .clk   (clk),
        .reset (reset),
        .clr   (step_clr_s),
        .en    (step_en_s),
        .tick  (frame_tick),
        .wrap  (step_wrap_s)
    );

    frame_divider #(.N(DWELL_MOD)) u_dwell_div (
        .clk   (clk),
        .reset (reset),
        .clr   (dwell_clr_s),
        .en    (dwell_en_s),
        .tick  (frame_tick),
        .wrap  (dwell_wrap_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: restart, then pause, then step/dwell progress.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD, ST_RUN, ST_DWELL, ST_HOLD: begin
                if (restart) begin
                    state_nxt_s = ST_LOAD;
                end else if (!go) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    case (state_r)
                        ST_LOAD: state_nxt_s = ST_RUN;
                        ST_RUN: begin
                            if (reverse_s && HAS_DWELL) begin
                                state_nxt_s = ST_DWELL;
                            end else begin
                                state_nxt_s = ST_RUN;
                            end
                        end
                        ST_DWELL: begin
                            if (dwell_wrap_s) begin
                                state_nxt_s = ST_RUN;
                            end else begin
                                state_nxt_s = ST_DWELL;
                            end
                        end
                        ST_HOLD: state_nxt_s = ST_RUN;
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; a step decision at the limit turns around instead of pulsing.
    always_comb begin
        up_s = step_wrap_s & dir_r & ~at_max;
        dw_s = step_wrap_s & ~dir_r & ~at_min;
        ld_s = (state_r == ST_LOAD);
        if (state_r == ST_LOAD) begin
            dir_nxt_s = 1'b1;
        end else if (reverse_s) begin
            dir_nxt_s = ~dir_r;
        end else begin
            dir_nxt_s = dir_r;
        end
    end

    // Registered output pulses and direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_r  <= 1'b0;
            dw_r  <= 1'b0;
            ld_r  <= 1'b0;
            dir_r <= 1'b1;
        end else begin
            up_r  <= up_s;
            dw_r  <= dw_s;
            ld_r  <= ld_s;
            dir_r <= dir_nxt_s;
        end
    end

    assign UP    = up_r;
    assign DW    = dw_r;
    assign LD    = ld_r;
    assign dir   = dir_r;
    assign state = state_r;

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Directed bench for vline_motion_ctrl: a vector table for the main motion
// path plus hand sequences for pause, restart, zero dwell and async reset.
module tb_vline_motion_ctrl;
    import vline_pkg::*;

    logic clk = 1'b0;
    logic reset, frame_tick, go, restart, at_max, at_min;
    logic up_a, dw_a, ld_a, dir_a;
    logic up_b, dw_b, ld_b, dir_b;
    logic [2:0] st_a, st_b;
    logic [6:0] oa, ob;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic       go;
        logic       rs;
        logic       tk;
        logic       mx;
        logic       mn;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [25];

    always #5 clk = ~clk;

    vline_motion_ctrl #(.FRAMES_PER_STEP(2), .DWELL_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .go(go),
        .restart(restart), .at_max(at_max), .at_min(at_min),
        .UP(up_a), .DW(dw_a), .LD(ld_a), .dir(dir_a), .state(st_a)
    );

    vline_motion_ctrl #(.FRAMES_PER_STEP(2), .DWELL_FRAMES(0)) dut0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .go(go),
        .restart(restart), .at_max(at_max), .at_min(at_min),
        .UP(up_b), .DW(dw_b), .LD(ld_b), .dir(dir_b), .state(st_b)
    );

    assign oa = {up_a, dw_a, ld_a, dir_a, st_a};
    assign ob = {up_b, dw_b, ld_b, dir_b, st_b};

    function automatic logic [6:0] ex(input logic u, input logic d, input logic l,
                                      input logic r, input logic [2:0] s);
        return {u, d, l, r, s};
    endfunction

    function automatic vec_t mk(input logic g, input logic rs, input logic tk,
                                input logic mx, input logic mn, input logic [6:0] e);
        vec_t v;
        v.go = g; v.rs = rs; v.tk = tk; v.mx = mx; v.mn = mn; v.exp = e;
        return v;
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got {UP,DW,LD,dir,state}=%07b, expected %07b", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic g, input logic rs, input logic tk,
                       input logic mx, input logic mn);
        go = g; restart = rs; frame_tick = tk; at_max = mx; at_min = mn;
    endtask

    // Drive one cycle of inputs on both DUTs, then compare the selected one.
    task automatic stp(input string nm, input logic g, input logic rs, input logic tk,
                       input logic mx, input logic mn, input logic [6:0] e,
                       input logic use_b);
        drv(g, rs, tk, mx, mn);
        cyc();
        check(nm, use_b ? ob : oa, e);
    endtask

    initial begin
        int ups;

        tbl[0]  = mk(0, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_IDLE));
        tbl[1]  = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_LOAD));
        tbl[2]  = mk(1, 0, 0, 0, 0, ex(0, 0, 1, 1, ST_RUN));
        tbl[3]  = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN));
        tbl[4]  = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_RUN));
        tbl[5]  = mk(1, 0, 1, 0, 0, ex(1, 0, 0, 1, ST_RUN));
        tbl[6]  = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_RUN));
        tbl[7]  = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN));
        tbl[8]  = mk(1, 0, 1, 0, 0, ex(1, 0, 0, 1, ST_RUN));
        tbl[9]  = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN));
        tbl[10] = mk(1, 0, 1, 1, 0, ex(0, 0, 0, 0, ST_DWELL));
        tbl[11] = mk(1, 0, 1, 1, 0, ex(0, 0, 0, 0, ST_DWELL));
        tbl[12] = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 0, ST_DWELL));
        tbl[13] = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_DWELL));
        tbl[14] = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_RUN));
        tbl[15] = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_RUN));
        tbl[16] = mk(1, 0, 1, 0, 0, ex(0, 1, 0, 0, ST_RUN));
        tbl[17] = mk(1, 0, 0, 0, 0, ex(0, 0, 0, 0, ST_RUN));
        tbl[18] = mk(1, 0, 1, 1, 1, ex(0, 0, 0, 0, ST_RUN));
        tbl[19] = mk(1, 0, 1, 1, 1, ex(0, 0, 0, 1, ST_DWELL));
        tbl[20] = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_DWELL));
        tbl[21] = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_DWELL));
        tbl[22] = mk(1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN));
        tbl[23] = mk(1, 0, 1, 1, 1, ex(0, 0, 0, 1, ST_RUN));
        tbl[24] = mk(1, 0, 1, 0, 0, ex(1, 0, 0, 1, ST_RUN));

        reset = 1'b0;
        drv(0, 0, 0, 0, 0);
        cyc();
        cyc();
        check("reset_a", oa, ex(0, 0, 0, 1, ST_IDLE));
        check("reset_b", ob, ex(0, 0, 0, 1, ST_IDLE));
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            stp($sformatf("vec%0d", i), tbl[i].go, tbl[i].rs, tbl[i].tk,
                tbl[i].mx, tbl[i].mn, tbl[i].exp, 1'b0);
        end

        // Restart, then 10 ticks: five UP pulses, one after each even tick.
        stp("rst_load", 1, 1, 0, 0, 0, ex(0, 0, 0, 1, ST_LOAD), 1'b0);
        stp("rst_ld",   1, 0, 0, 0, 0, ex(0, 0, 1, 1, ST_RUN), 1'b0);
        ups = 0;
        for (int k = 0; k < 10; k++) begin
            stp($sformatf("tick%0d", k + 1), 1, 0, 1, 0, 0,
                ex(logic'(k % 2), 0, 0, 1, ST_RUN), 1'b0);
            ups += int'(up_a);
            stp($sformatf("gap%0d", k + 1), 1, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b0);
        end
        check("up_count", 7'(ups), 7'd5);

        // Pause with frame_cnt = 1; ticks during HOLD are ignored.
        stp("pre_hold",  1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b0);
        stp("hold_in",   0, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_HOLD), 1'b0);
        for (int k = 0; k < 5; k++) begin
            stp($sformatf("hold_tick%0d", k), 0, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_HOLD), 1'b0);
            stp($sformatf("hold_gap%0d", k),  0, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_HOLD), 1'b0);
        end
        stp("hold_out",  1, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b0);
        stp("hold_step", 1, 0, 1, 0, 0, ex(1, 0, 0, 1, ST_RUN), 1'b0);

        // Turn around to dir = 0, then restart on a step-decision tick.
        stp("c_t1",     1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b0);
        stp("c_lim",    1, 0, 1, 1, 0, ex(0, 0, 0, 0, ST_DWELL), 1'b0);
        stp("c_dw1",    1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_DWELL), 1'b0);
        stp("c_dw2",    1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_DWELL), 1'b0);
        stp("c_dw3",    1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_RUN), 1'b0);
        stp("c_t2",     1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_RUN), 1'b0);
        stp("c_rst",    1, 1, 1, 0, 0, ex(0, 0, 0, 0, ST_LOAD), 1'b0);
        stp("c_ld",     1, 0, 0, 0, 0, ex(0, 0, 1, 1, ST_RUN), 1'b0);
        stp("c_fc0",    1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b0);
        stp("c_up",     1, 0, 1, 0, 0, ex(1, 0, 0, 1, ST_RUN), 1'b0);

        // go falls on a step-decision tick: HOLD, no pulse, count kept.
        stp("g_t1",     1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b0);
        stp("g_fall",   0, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_HOLD), 1'b0);
        stp("g_back",   1, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b0);
        stp("g_up",     1, 0, 1, 0, 0, ex(1, 0, 0, 1, ST_RUN), 1'b0);

        // Asynchronous reset in the middle of a dwell.
        stp("d_t1",     1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b0);
        stp("d_lim",    1, 0, 1, 1, 0, ex(0, 0, 0, 0, ST_DWELL), 1'b0);
        stp("d_dw1",    1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_DWELL), 1'b0);
        drv(1, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_dwell", oa, ex(0, 0, 0, 1, ST_IDLE));
        cyc();
        reset = 1'b1;

        // Zero-dwell instance: turn around in RUN with no pulse.
        stp("z_load",   1, 0, 0, 0, 0, ex(0, 0, 0, 1, ST_LOAD), 1'b1);
        stp("z_ld",     1, 0, 0, 0, 0, ex(0, 0, 1, 1, ST_RUN), 1'b1);
        stp("z_t1",     1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b1);
        stp("z_max",    1, 0, 1, 1, 0, ex(0, 0, 0, 0, ST_RUN), 1'b1);
        stp("z_t2",     1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_RUN), 1'b1);
        stp("z_dw",     1, 0, 1, 0, 0, ex(0, 1, 0, 0, ST_RUN), 1'b1);
        stp("z_t3",     1, 0, 1, 0, 0, ex(0, 0, 0, 0, ST_RUN), 1'b1);
        stp("z_min",    1, 0, 1, 0, 1, ex(0, 0, 0, 1, ST_RUN), 1'b1);
        stp("z_t4",     1, 0, 1, 0, 0, ex(0, 0, 0, 1, ST_RUN), 1'b1);
        stp("z_up",     1, 0, 1, 0, 0, ex(1, 0, 0, 1, ST_RUN), 1'b1);

        // Reset while UP is high clears it without waiting for a clock.
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pulse", ob, ex(0, 0, 0, 1, ST_IDLE));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
